// File: rtl/conv55_pkg.sv
// Shared constants and helpers for the 5x5 window generator.
package conv55_pkg;

   localparam int K       = 5;   // window edge
   localparam int KK      = 25;  // pixels per window
   localparam int LB_ROWS = 4;   // buffered previous lines

   // Bits needed to hold 0..v-1 (minimum 1).
   function automatic int clogb2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << r) < v) r = i + 1;
      end
      return r;
   endfunction

   // Flat window index of row r, column c; row 0 is the oldest line.
   function automatic int idx(input int r, input int c);
      return r * K + c;
   endfunction

endpackage

// File: rtl/conv55_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv55_window_gen.
import conv55_pkg::*;

interface conv55_window_gen_if #(parameter int P_IN = 12);
   logic                 in_valid;
   logic                 in_ready;
   logic [P_IN-1:0]      in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [KK*P_IN-1:0]   out_window;
   logic                 frame_done;

   // Block side: consumes pixels, produces windows.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_window, frame_done
   );

   // Environment side: produces pixels, consumes windows.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_window, frame_done
   );
endinterface

// File: rtl/conv55_line_buf.sv
// Line buffer RAM: one entry per image column, write port and read port
// share the column address; a read during a write returns the old word.
module conv55_line_buf #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 48,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[raddr];

   // Storage is never cleared; contents are refilled by the pixel stream.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

endmodule

// File: rtl/conv55_window_gen.sv
// 5x5 sliding-window generator: buffers four lines of a raster pixel stream
// and emits one 25-pixel window per fully-inside output position.
module conv55_window_gen
   import conv55_pkg::*;
#(
   parameter int P_IN  = 12,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32
) (
   input  logic               clk,
   input  logic               rst,
   conv55_window_gen_if.slave bus
);

   localparam int COL_W = clogb2(IMG_W);
   localparam int ROW_W = clogb2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam int LBW = LB_ROWS * P_IN;

   logic [COL_W-1:0]           col_q, col_d;
   logic [ROW_W-1:0]           row_q, row_d;
   logic                       out_valid_q, out_valid_d;
   logic                       frame_done_q, frame_done_d;
   logic [KK-1:0][P_IN-1:0]    win_q, win_d;
   logic [LBW-1:0]             lb_rd, lb_wr;
   logic                       acc, cons, emit;

   // The window register doubles as the output register: it only moves on an
   // accept, and an accept is only possible when the held window is consumed.
   assign bus.in_ready   = !out_valid_q || bus.out_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_window = win_q;
   assign bus.frame_done = frame_done_q;

   assign acc  = bus.in_valid && bus.in_ready;
   assign cons = out_valid_q && bus.out_ready;
   // Gating on row>=4 keeps rows of a previous frame or pre-reset data out.
   assign emit = acc && (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));

   // Each buffer word is {lb3,lb2,lb1,lb0}; writing back drops lb3 and
   // pushes the new pixel in as lb0.
   assign lb_wr = {lb_rd[LBW-P_IN-1:0], bus.in_data};

   conv55_line_buf #(
      .DEPTH (IMG_W),
      .WIDTH (LBW),
      .AW    (COL_W)
   ) u_line_buf (
      .clk   (clk),
      .we    (acc),
      .waddr (col_q),
      .wdata (lb_wr),
      .raddr (col_q),
      .rdata (lb_rd)
   );

   // Raster position counters, wrapping at line and frame end.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (acc) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   // Shift the window left one column and load the new right-hand column.
   always_comb begin
      win_d = win_q;
      if (acc) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K - 1; c++)
               win_d[idx(r, c)] = win_q[idx(r, c + 1)];
         for (int r = 0; r < LB_ROWS; r++)
            win_d[idx(r, K - 1)] = lb_rd[(LB_ROWS - 1 - r) * P_IN +: P_IN];
         win_d[idx(K - 1, K - 1)] = bus.in_data;
      end
   end

   // Output valid / frame_done: a new window wins over a plain consume.
   always_comb begin
      out_valid_d  = out_valid_q;
      frame_done_d = frame_done_q;
      if (emit) begin
         out_valid_d  = 1'b1;
         frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end else if (cons) begin
         out_valid_d  = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Window data is don't-care until refilled, so it is not reset.
   always_ff @(posedge clk) begin
      win_q <= win_d;
   end

endmodule

// File: tb/tb_conv55_window_gen.sv
// Scoreboard bench for conv55_window_gen: an 8x8 instance for the directed
// frame tests and an 11x6 instance for random gaps / backpressure.
module tb_conv55_window_gen;
   import conv55_pkg::*;

   localparam int P  = 12;
   localparam int AW = 8;
   localparam int AH = 8;
   localparam int BW = 11;
   localparam int BH = 6;

   typedef struct {
      logic [KK*P-1:0] win;
      logic            fd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   conv55_window_gen_if #(.P_IN(P)) ia ();
   conv55_window_gen_if #(.P_IN(P)) ib ();

   conv55_window_gen #(.P_IN(P), .IMG_W(AW), .IMG_H(AH)) dut_a (
      .clk(clk), .rst(rst_a), .bus(ia.slave));
   conv55_window_gen #(.P_IN(P), .IMG_W(BW), .IMG_H(BH)) dut_b (
      .clk(clk), .rst(rst_b), .bus(ib.slave));

   int errors = 0;
   int checks = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic [KK*P-1:0] loga[$];
   int beats_a = 0;
   int first_beats = -1;
   int nb = 0;
   bit rnd_b = 1'b0;

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // mode 0: base + r*8 + c ; mode 1: scrambled values for the 11x6 image
   function automatic int pix(input int mode, input int base, input int r, input int c);
      if (mode == 0) return base + r * AW + c;
      return (r * 131 + c * 29 + 7) % 4096;
   endfunction

   function automatic logic [KK*P-1:0] model(input int mode, input int base,
                                              input int rr, input int cc);
      logic [KK*P-1:0] m;
      m = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            m[idx(r, c)*P +: P] = P'(pix(mode, base, rr - 4 + r, cc - 4 + c));
      return m;
   endfunction

   function automatic int getw(input logic [KK*P-1:0] w, input int k);
      return int'(w[k*P +: P]);
   endfunction

   // Monitor A: pop expected window on each consume.
   always @(negedge clk) begin
      if (rst_a === 1'b0 && ia.out_valid === 1'b1 && ia.out_ready === 1'b1) begin
         if (first_beats < 0) first_beats = beats_a;
         loga.push_back(ia.out_window);
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_window: got win=%h with empty queue", ia.out_window);
         end else begin
            ea = qa.pop_front();
            if (ia.out_window !== ea.win || ia.frame_done !== ea.fd) begin
               errors++;
               $display("FAIL a_window: got fd=%0b win=%h expected fd=%0b win=%h",
                        ia.frame_done, ia.out_window, ea.fd, ea.win);
            end
         end
      end
   end

   // Monitor B: same for the random-timing instance.
   always @(negedge clk) begin
      if (rst_b === 1'b0 && ib.out_valid === 1'b1 && ib.out_ready === 1'b1) begin
         nb++;
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_window: got win=%h with empty queue", ib.out_window);
         end else begin
            eb = qb.pop_front();
            if (ib.out_window !== eb.win || ib.frame_done !== eb.fd) begin
               errors++;
               $display("FAIL b_window: got fd=%0b win=%h expected fd=%0b win=%h",
                        ib.frame_done, ib.out_window, eb.fd, eb.win);
            end
         end
      end
   end

   // Random downstream readiness for instance B.
   always @(posedge clk) begin
      #1;
      if (rnd_b) ib.out_ready = ($urandom_range(0, 2) != 0);
   end

   task automatic send_a(input int v);
      int n;
      n = 0;
      ia.in_valid = 1'b1;
      ia.in_data  = P'(v);
      @(negedge clk);
      while (ia.in_ready !== 1'b1) begin
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL a_accept_timeout: in_ready stuck at %b, required 1", ia.in_ready);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      beats_a++;
      #1 ia.in_valid = 1'b0;
   endtask

   task automatic send_b(input int v);
      int n;
      n = 0;
      ib.in_valid = 1'b1;
      ib.in_data  = P'(v);
      @(negedge clk);
      while (ib.in_ready !== 1'b1) begin
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL b_accept_timeout: in_ready stuck at %b, required 1", ib.in_ready);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 ib.in_valid = 1'b0;
   endtask

   task automatic frame_a(input int base);
      exp_t e;
      for (int r = 0; r < AH; r++)
         for (int c = 0; c < AW; c++) begin
            if (r >= 4 && c >= 4) begin
               e.win = model(0, base, r, c);
               e.fd  = (r == AH - 1) && (c == AW - 1);
               qa.push_back(e);
            end
            send_a(pix(0, base, r, c));
         end
   endtask

   task automatic drain_a(input string nm);
      repeat (10) @(negedge clk);
      chk(nm, qa.size(), 0);
   endtask

   // Hold out_ready low for 3 cycles on a pending window mid-frame.
   task automatic stall_a();
      int n;
      logic [KK*P-1:0] held;
      n = 0;
      @(negedge clk);
      while (ia.out_valid !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("t3_window_seen", int'(ia.out_valid), 1);
      @(posedge clk);
      #1 ia.out_ready = 1'b0;
      held = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) begin
            held = ia.out_window;
            chk("t3_pending", int'(ia.out_valid), 1);
         end else begin
            checks++;
            if (ia.out_window !== held) begin
               errors++;
               $display("FAIL t3_hold: got win=%h required win=%h", ia.out_window, held);
            end
         end
         chk("t3_in_ready_low", int'(ia.in_ready), 0);
      end
      @(posedge clk);
      #1 ia.out_ready = 1'b1;
   endtask

   initial begin
      exp_t e;
      rst_a = 1'b1; rst_b = 1'b1;
      ia.in_valid = 1'b0; ia.in_data = '0; ia.out_ready = 1'b1;
      ib.in_valid = 1'b0; ib.in_data = '0; ib.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(ia.out_valid), 0);
      chk("rst_frame_done", int'(ia.frame_done), 0);
      chk("rst_in_ready", int'(ia.in_ready), 1);
      @(posedge clk); #1;

      // Tests 1/2: one continuous frame
      loga.delete();
      first_beats = -1;
      beats_a = 0;
      frame_a(0);
      drain_a("t1_queue_empty");
      chk("t1_first_latency_beats", first_beats, 37);
      chk("t2_window_count", loga.size(), 16);
      if (loga.size() == 16) begin
         chk("t1_win0",  getw(loga[0], 0),  0);
         chk("t1_win4",  getw(loga[0], 4),  4);
         chk("t1_win12", getw(loga[0], 12), 18);
         chk("t1_win20", getw(loga[0], 20), 32);
         chk("t1_win24", getw(loga[0], 24), 36);
         chk("t2_last_win24", getw(loga[15], 24), 63);
         chk("t2_last_win0",  getw(loga[15], 0),  27);
      end
      @(posedge clk); #1;

      // Test 3: backpressure while a window is pending
      loga.delete();
      fork
         frame_a(0);
         stall_a();
      join
      drain_a("t3_queue_empty");
      chk("t3_window_count", loga.size(), 16);
      @(posedge clk); #1;

      // Test 4: reset mid-frame, then a clean frame
      for (int i = 0; i < 20; i++) send_a(pix(0, 50, i / AW, i % AW));
      rst_a = 1'b1;
      @(posedge clk);
      #1 rst_a = 1'b0;
      @(negedge clk);
      chk("t4_out_valid_after_rst", int'(ia.out_valid), 0);
      chk("t4_in_ready_after_rst", int'(ia.in_ready), 1);
      @(posedge clk); #1;
      loga.delete();
      frame_a(0);
      drain_a("t4_queue_empty");
      chk("t4_window_count", loga.size(), 16);
      @(posedge clk); #1;

      // Test 5: two frames back-to-back, second offset by 100
      loga.delete();
      frame_a(0);
      frame_a(100);
      drain_a("t5_queue_empty");
      chk("t5_window_count", loga.size(), 32);
      if (loga.size() == 32) begin
         chk("t5_f2_win0",  getw(loga[16], 0),  100);
         chk("t5_f2_win24", getw(loga[16], 24), 136);
      end

      // Test 6: 11x6 with random input gaps and random out_ready
      rnd_b = 1'b1;
      for (int r = 0; r < BH; r++)
         for (int c = 0; c < BW; c++) begin
            if (r >= 4 && c >= 4) begin
               e.win = model(1, 0, r, c);
               e.fd  = (r == BH - 1) && (c == BW - 1);
               qb.push_back(e);
            end
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send_b(pix(1, 0, r, c));
         end
      rnd_b = 1'b0;
      @(posedge clk);
      #2 ib.out_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_queue_empty", qb.size(), 0);
      chk("t6_window_count", nb, 14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

endmodule
